// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX/MEM request, data-memory bus and MEM/WB result bundle
interface mem_access_unit_if;
   logic        ex_valid;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [1:0]  ex_size;
   logic        ex_unsigned;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [31:0] ex_alu_result;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_data;
   logic        stall;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign_err;
   modport slave (
      input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned, ex_addr,
             ex_wdata, ex_alu_result, ex_rd, ex_reg_write, mem_data,
      output mem_read_enable, mem_write_enable, mem_address, mem_write_data, stall,
             wb_valid, wb_reg_write, wb_rd, wb_data, misalign_err
   );
   modport master (
      output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned, ex_addr,
             ex_wdata, ex_alu_result, ex_rd, ex_reg_write, mem_data,
      input  mem_read_enable, mem_write_enable, mem_address, mem_write_data, stall,
             wb_valid, wb_reg_write, wb_rd, wb_data, misalign_err
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller with read-modify-write sub-word stores
module mem_access_unit #(
   parameter int IDX_W = 3
) (
   input logic clk,
   input logic reset,
   mem_access_unit_if.slave bus
);
   typedef enum logic {IDLE, RMW_WR} state_t;
   state_t state, state_nxt;
   logic [IDX_W-1:0] idx, hold_idx;
   logic [1:0] hold_lane;
   logic hold_byte;
   logic [15:0] hold_wdata;
   logic [31:0] hold_word;
   logic mem_op, misalign, err, load, store, word_store, sub_store;
   logic [15:0] lane_bits;
   logic [31:0] load_data, lane_mask, merged;
   assign idx = bus.ex_addr[IDX_W+1:2];
   assign mem_op = bus.ex_valid && (bus.ex_mem_read || bus.ex_mem_write);
   assign misalign = (bus.ex_size == 2'b01 && bus.ex_addr[0]) ||
                     (bus.ex_size == 2'b10 && bus.ex_addr[1:0] != 2'b00) ||
                     bus.ex_size == 2'b11;
   assign err = mem_op && (misalign || (bus.ex_mem_read && bus.ex_mem_write));
   assign load = mem_op && !err && bus.ex_mem_read;
   assign store = mem_op && !err && bus.ex_mem_write;
   assign word_store = store && bus.ex_size == 2'b10;
   assign sub_store = store && !bus.ex_size[1];
   // aligned halves have addr[0]=0, so one byte-granular shift serves both sizes
   assign lane_bits = 16'(bus.mem_data >> {bus.ex_addr[1:0], 3'b000});
   assign load_data = bus.ex_size == 2'b00 ? {{24{!bus.ex_unsigned && lane_bits[7]}}, lane_bits[7:0]} :
                      bus.ex_size == 2'b01 ? {{16{!bus.ex_unsigned && lane_bits[15]}}, lane_bits} :
                      bus.mem_data;
   assign lane_mask = hold_byte ? 32'h0000_00FF << {hold_lane, 3'b000} : 32'h0000_FFFF << {hold_lane[1], 4'b0000};
   assign merged = (hold_word & ~lane_mask) | ({2{hold_wdata}} & lane_mask);
   always_ff @(posedge clk)
      state <= !reset ? IDLE : state_nxt;
   always_comb
      state_nxt = (state == IDLE && sub_store) ? RMW_WR : IDLE;
   always_comb begin
      bus.mem_read_enable = reset && state == IDLE && (load || sub_store);
      bus.mem_write_enable = reset && (state == RMW_WR || (state == IDLE && word_store));
      bus.stall = reset && state == IDLE && sub_store;
      bus.mem_address = {{(32-IDX_W){1'b0}}, state == RMW_WR ? hold_idx : idx};
      bus.mem_write_data = state == RMW_WR ? merged : bus.ex_wdata;
   end
   // byte stores replicate the byte so the lane mask alone picks the target lane
   always_ff @(posedge clk)
      if (state == IDLE && sub_store) begin
         hold_idx <= idx;
         hold_lane <= bus.ex_addr[1:0];
         hold_byte <= !bus.ex_size[0];
         hold_wdata <= bus.ex_size[0] ? bus.ex_wdata[15:0] : {2{bus.ex_wdata[7:0]}};
         hold_word <= bus.mem_data;
      end
   always_ff @(posedge clk)
      if (!reset) begin
         bus.wb_valid <= 1'b0;
         bus.wb_reg_write <= 1'b0;
         bus.wb_rd <= 5'd0;
         bus.wb_data <= 32'd0;
         bus.misalign_err <= 1'b0;
      end else if (state == RMW_WR) begin
         bus.wb_valid <= 1'b1;
         bus.wb_reg_write <= 1'b0;
         bus.misalign_err <= 1'b0;
      end else begin
         bus.wb_valid <= bus.ex_valid && !sub_store;
         bus.wb_reg_write <= bus.ex_valid && !err && !bus.ex_mem_write && bus.ex_reg_write;
         bus.misalign_err <= err;
         if (bus.ex_valid && !err && !bus.ex_mem_write) begin
            bus.wb_rd <= bus.ex_rd;
            bus.wb_data <= bus.ex_mem_read ? load_data : bus.ex_alu_result;
         end
      end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed test-plan cases plus random traffic checked against a byte-level memory model
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic preload = 1'b1;
   always #5 clk = ~clk;
   mem_access_unit_if bus();
   mem_access_unit #(.IDX_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
   logic [31:0] tmem [8];
   logic [31:0] ref_mem [8];
   assign bus.mem_data = tmem[bus.mem_address[2:0]];
   always @(posedge clk)
      if (preload) begin
         for (int i = 0; i < 8; i++) tmem[i] <= ref_mem[i];
      end else if (bus.mem_write_enable) tmem[bus.mem_address[2:0]] <= bus.mem_write_data;
   typedef struct {
      bit rd, wr, st, v, rw, mis, chk;
      logic [31:0] addr, wdata, data;
      logic [4:0] rdi;
   } rec_t;
   rec_t q[$];
   int checks = 0;
   int errors = 0;
   bit m_def = 1'b1;
   logic [4:0] m_rd = 5'd0;
   logic [31:0] m_data = 32'd0;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chkb(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask
   function automatic rec_t base();
      rec_t r;
      r = '{default: 0};
      r.chk = m_def;
      r.rdi = m_rd;
      r.data = m_data;
      return r;
   endfunction
   function automatic logic [31:0] ld_model(logic [31:0] w, int lane, int nb, bit uns);
      longint v = 0;
      for (int k = 0; k < nb; k++) v = v | (longint'((w >> (8 * (lane + k))) & 32'hFF) << (8 * k));
      if (!uns && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction
   function automatic logic [31:0] st_model(logic [31:0] w, int lane, int nb, logic [31:0] d);
      logic [31:0] r = w;
      for (int k = 0; k < nb; k++) r[8*(lane+k) +: 8] = d[8*k +: 8];
      return r;
   endfunction
   task automatic drive(bit v, bit rd, bit wr, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] alu, logic [4:0] rdi, bit rw, bit rst_n);
      reset = rst_n;
      bus.ex_valid = v;
      bus.ex_mem_read = rd;
      bus.ex_mem_write = wr;
      bus.ex_size = sz;
      bus.ex_unsigned = uns;
      bus.ex_addr = a;
      bus.ex_wdata = wd;
      bus.ex_alu_result = alu;
      bus.ex_rd = rdi;
      bus.ex_reg_write = rw;
   endtask
   task automatic drive_junk(bit v, bit rst_n);
      drive(v, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            5'($urandom), 1'($urandom), rst_n);
   endtask
   task automatic idle();
      @(negedge clk);
      drive_junk(1'b0, 1'b1);
      q.push_back(base());
   endtask
   task automatic rst();
      @(negedge clk);
      drive_junk(1'($urandom), 1'b0);
      m_def = 1'b1;
      m_rd = 5'd0;
      m_data = 32'd0;
      q.push_back(base());
   endtask
   task automatic op(bit rd, bit wr, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd,
                     logic [31:0] alu, logic [4:0] rdi, bit rw);
      rec_t r;
      int idx, lane, nb;
      bit err;
      @(negedge clk);
      drive(1'b1, rd, wr, sz, uns, a, wd, alu, rdi, rw, 1'b1);
      idx = int'(a[4:2]);
      lane = int'(a[1:0]);
      nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      err = (rd || wr) && (sz == 2'd3 || (rd && wr) || lane % nb != 0);
      r = base();
      if (err) begin
         r.v = 1; r.mis = 1; r.chk = 0; m_def = 0;
      end else if (rd) begin
         m_rd = rdi; m_data = ld_model(ref_mem[idx], lane, nb, uns); m_def = 1;
         r.rd = 1; r.addr = idx; r.v = 1; r.rw = rw; r.chk = 1; r.rdi = m_rd; r.data = m_data;
      end else if (wr && nb == 4) begin
         ref_mem[idx] = wd;
         r.wr = 1; r.addr = idx; r.wdata = wd; r.v = 1; r.chk = 0; m_def = 0;
      end else if (wr) begin
         r.rd = 1; r.st = 1; r.addr = idx; r.chk = 0; m_def = 0;
         q.push_back(r);
         @(negedge clk);
         drive_junk(1'($urandom), 1'b1);
         ref_mem[idx] = st_model(ref_mem[idx], lane, nb, wd);
         r = base();
         r.wr = 1; r.addr = idx; r.wdata = ref_mem[idx]; r.v = 1;
      end else begin
         m_rd = rdi; m_data = alu; m_def = 1;
         r.v = 1; r.rw = rw; r.chk = 1; r.rdi = rdi; r.data = alu;
      end
      q.push_back(r);
   endtask
   task automatic sample();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            r = q.pop_front();
            chkb("mem_read_enable", bus.mem_read_enable, r.rd);
            chkb("mem_write_enable", bus.mem_write_enable, r.wr);
            chkb("stall", bus.stall, r.st);
            if (r.rd || r.wr) chk("mem_address", bus.mem_address, r.addr);
            if (r.wr) chk("mem_write_data", bus.mem_write_data, r.wdata);
            @(posedge clk);
            #1;
            chkb("wb_valid", bus.wb_valid, r.v);
            chkb("wb_reg_write", bus.wb_reg_write, r.rw);
            chkb("misalign_err", bus.misalign_err, r.mis);
            if (r.chk) begin
               chk("wb_rd", 32'(bus.wb_rd), 32'(r.rdi));
               chk("wb_data", bus.wb_data, r.data);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d records pending", q.size());
      $fatal(1);
   end
   initial begin
      rec_t r;
      logic [31:0] a;
      logic [1:0] sz;
      int t;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ref_mem[i] = $urandom;
      ref_mem[0] = 32'h04030201;
      ref_mem[1] = 32'h08070605;
      ref_mem[2] = 32'h03030003;
      rst();
      rst();
      sample();
      preload = 1'b0;
      chk("reset_wb_data", bus.wb_data, 32'h0);
      op(1, 0, 2'd0, 1, 32'd5, 32'd0, 32'd0, 5'd3, 1);
      sample();
      chk("tp1_lbu_addr5", bus.wb_data, 32'h00000006);
      op(0, 1, 2'd0, 0, 32'd0, 32'h80, 32'd0, 5'd0, 0);
      sample();
      chk("tp2_sb_word0", tmem[0], 32'h04030280);
      op(1, 0, 2'd0, 0, 32'd0, 32'd0, 32'd0, 5'd4, 1);
      sample();
      chk("tp2_lb_signed", bus.wb_data, 32'hFFFFFF80);
      op(1, 0, 2'd1, 1, 32'd6, 32'd0, 32'd0, 5'd5, 1);
      sample();
      chk("tp3_lhu_addr6", bus.wb_data, 32'h00000807);
      op(0, 1, 2'd1, 0, 32'd6, 32'h1234BEEF, 32'd0, 5'd0, 0);
      op(1, 0, 2'd2, 0, 32'd4, 32'd0, 32'd0, 5'd6, 1);
      sample();
      chk("tp3_lw_after_sh", bus.wb_data, 32'hBEEF0605);
      op(1, 0, 2'd1, 0, 32'd1, 32'd0, 32'd0, 5'd7, 1);
      sample();
      chkb("tp4_lh_misalign", bus.misalign_err, 1'b1);
      op(1, 0, 2'd2, 0, 32'd2, 32'd0, 32'd0, 5'd7, 1);
      sample();
      chkb("tp4_lw_misalign_rw", bus.wb_reg_write, 1'b0);
      idle();
      sample();
      chkb("tp4_misalign_pulse_end", bus.misalign_err, 1'b0);
      op(1, 0, 2'd2, 0, 32'h20, 32'd0, 32'd0, 5'd8, 1);
      sample();
      chk("tp4_lw_wrap", bus.wb_data, 32'h04030280);
      @(negedge clk);
      drive(1, 0, 1, 2'd0, 0, 32'd8, 32'hAA, 32'd0, 5'd0, 0, 1'b1);
      m_def = 1; m_rd = 5'd0; m_data = 32'd0;
      r = base();
      r.rd = 1; r.st = 1; r.addr = 32'd2;
      q.push_back(r);
      #3 reset = 1'b0;
      idle();
      sample();
      chk("tp5_reset_entering_mem2", tmem[2], 32'h03030003);
      chkb("tp5_reset_wb_valid", bus.wb_valid, 1'b0);
      op(1, 0, 2'd2, 0, 32'd8, 32'd0, 32'd0, 5'd2, 1);
      @(negedge clk);
      drive(1, 0, 1, 2'd0, 0, 32'd8, 32'hAA, 32'd0, 5'd0, 0, 1'b1);
      r = base();
      r.rd = 1; r.st = 1; r.addr = 32'd2; r.chk = 0; m_def = 0;
      q.push_back(r);
      rst();
      idle();
      sample();
      chk("tp5_reset_in_rmw_mem2", tmem[2], 32'h03030003);
      chk("tp5_reset_wb_data", bus.wb_data, 32'h0);
      op(0, 1, 2'd2, 0, 32'd12, 32'h12345678, 32'd0, 5'd0, 1);
      op(1, 0, 2'd2, 0, 32'd12, 32'd0, 32'd0, 5'd10, 1);
      sample();
      chk("tp6_sw_lw", bus.wb_data, 32'h12345678);
      op(0, 0, 2'd3, 0, 32'd3, 32'd0, 32'h55, 5'd9, 1);
      sample();
      chk("tp6_alu_data", bus.wb_data, 32'h55);
      chk("tp6_alu_rd", 32'(bus.wb_rd), 32'd9);
      for (int n = 0; n < 400; n++) begin
         t = $urandom_range(0, 19);
         if (t == 0) rst();
         else if (t < 3) idle();
         else begin
            sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
               if (sz == 2'd1) a[0] = 1'b0;
               if (sz == 2'd2) a[1:0] = 2'b00;
            end
            t = $urandom_range(0, 9);
            op(t < 4 || t == 9, (t >= 4 && t < 8) || t == 9, sz, 1'($urandom), a, $urandom, $urandom,
               5'($urandom), 1'($urandom));
         end
      end
      idle();
      repeat (2) @(posedge clk);
      #2;
      for (int i = 0; i < 8; i++) chk("final_mem", tmem[i], ref_mem[i]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
